// File: rtl/addr_issue.sv
// Consumer side of the register-address queue: mirrors queue occupancy, pops rs/rt pairs and
// issues each one once both source registers are clear in a busy-register scoreboard.
module addr_issue #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CWIDTH = 5
) (
    input  logic              ai_clk,
    input  logic              ai_rst,
    input  logic              ai_i_push,
    output logic              ai_o_pop,
    input  logic [AWIDTH-1:0] ai_i_addr_rs,
    input  logic [AWIDTH-1:0] ai_i_addr_rt,
    input  logic              ai_i_set_en,
    input  logic [AWIDTH-1:0] ai_i_set_addr,
    input  logic              ai_i_wb_en,
    input  logic [AWIDTH-1:0] ai_i_wb_addr,
    output logic              ai_o_valid,
    input  logic              ai_i_ready,
    output logic [AWIDTH-1:0] ai_o_addr_rs,
    output logic [AWIDTH-1:0] ai_o_addr_rt,
    output logic [CWIDTH-1:0] ai_o_count,
    output logic              ai_o_empty,
    output logic              ai_o_stall,
    output logic              ai_o_overflow
);

    localparam int unsigned REGS = 1 << AWIDTH;

    typedef enum logic [1:0] {StIdle, StPop, StWait, StCheck} state_e;

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic [REGS-1:0]   busy_q, busy_d;
    logic [AWIDTH-1:0] rs_q, rs_d;
    logic [AWIDTH-1:0] rt_q, rt_d;
    logic              hold_q, hold_d;

    logic rs_busy, rt_busy, in_check, pop, valid, accept;

    // A writeback in this cycle already frees its register for the busy test.
    always_comb begin
        rs_busy  = busy_q[rs_q] && !(ai_i_wb_en && (ai_i_wb_addr == rs_q));
        rt_busy  = busy_q[rt_q] && !(ai_i_wb_en && (ai_i_wb_addr == rt_q));
        in_check = (state_q == StCheck);
        pop      = (state_q == StPop);
        // hold_q keeps valid up once shown, even if an operand turns busy afterwards.
        valid    = in_check && (hold_q || (!rs_busy && !rt_busy));
        accept   = valid && ai_i_ready;
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (ai_i_push && !pop) begin
            if (count_q == CWIDTH'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CWIDTH'(1);
            end
        end else if (!ai_i_push && pop) begin
            count_d = count_q - CWIDTH'(1);
        end
        empty_d = (count_d == '0);
    end

    // Set beats a same-cycle writeback to the same register; register 0 is never busy.
    always_comb begin
        busy_d = busy_q;
        if (ai_i_wb_en) begin
            busy_d[ai_i_wb_addr] = 1'b0;
        end
        if (ai_i_set_en) begin
            busy_d[ai_i_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hold_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StWait;
            end
            StWait: begin
                rs_d    = ai_i_addr_rs;
                rt_d    = ai_i_addr_rt;
                state_d = StCheck;
            end
            StCheck: begin
                if (accept) begin
                    state_d = (count_d != '0) ? StPop : StIdle;
                end else begin
                    hold_d = valid;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ai_clk) begin
        if (ai_rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            busy_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            hold_q     <= hold_d;
        end
    end

    assign ai_o_pop      = pop;
    assign ai_o_valid    = valid;
    assign ai_o_stall    = in_check && !valid;
    assign ai_o_addr_rs  = rs_q;
    assign ai_o_addr_rt  = rt_q;
    assign ai_o_count    = count_q;
    assign ai_o_empty    = empty_q;
    assign ai_o_overflow = overflow_q;

endmodule

// File: doc/addr_issue.md
# addr_issue

Consumer end of the register-address queue in the MIPS superscalar front end. It tracks queue occupancy from the write strobe and pops one rs/rt address pair at a time. It holds each pair until both source registers are free in a busy-register scoreboard, then presents the pair to the operand-read stage with a valid/ready handshake.

## Interface
- AWIDTH, 5, register address width (matches the queue's address width)
- DEPTH, 16, address-queue depth being mirrored; power of two
- CWIDTH, 5, occupancy counter width; must hold DEPTH
- ai_clk  input  1  clock; all state updates on rising edge
- ai_rst  input  1  reset; synchronous, active-high
- ai_i_push  input  1  queue write strobe, the same signal that drives the queue's write enable
- ai_o_pop  output  1  queue read enable; one-cycle pulse per pair
- ai_i_addr_rs  input  AWIDTH  queue rs output; valid the cycle after the pop pulse
- ai_i_addr_rt  input  AWIDTH  queue rt output; valid the cycle after the pop pulse
- ai_i_set_en  input  1  mark a destination register busy
- ai_i_set_addr  input  AWIDTH  destination register to mark busy
- ai_i_wb_en  input  1  writeback; clears a busy bit
- ai_i_wb_addr  input  AWIDTH  register being written back
- ai_o_valid  output  1  issued pair valid
- ai_i_ready  input  1  downstream accepts the pair
- ai_o_addr_rs  output  AWIDTH  issued rs
- ai_o_addr_rt  output  AWIDTH  issued rt
- ai_o_count  output  CWIDTH  entries in the queue not yet popped
- ai_o_empty  output  1  ai_o_count == 0
- ai_o_stall  output  1  pair held in CHECK because of a busy operand
- ai_o_overflow  output  1  sticky; set by a push while count == DEPTH

## Operation
- **Occupancy counter**
  - A push increments the count.
  - A pop (ai_o_pop high) decrements it.
  - Push and pop in the same cycle leave the count unchanged.
  - A push at count == DEPTH with no pop in that cycle is not counted and sets ai_o_overflow.
- **Scoreboard:** REGS = 2^AWIDTH busy bits.
  - set_en sets busy[set_addr].
  - wb_en clears busy[wb_addr].
  - If both target the same address in one cycle, the set wins.
  - Register 0 is never busy; writes to bit 0 are ignored.
- **Busy test:** an operand is busy if its bit is set and it is not being cleared by wb_en in the current cycle (same-cycle writeback bypass).
- **FSM states:** IDLE, POP, WAIT, CHECK.
  - IDLE: if count != 0, go to POP; otherwise stay.
  - POP: ai_o_pop = 1 for this cycle only; go to WAIT.
  - WAIT: capture ai_i_addr_rs/rt into the holding registers at the end of the cycle; go to CHECK.
  - CHECK, either operand busy: ai_o_stall = 1, ai_o_valid = 0; stay in CHECK.
  - CHECK, both operands free: ai_o_valid = 1 with the held pair on ai_o_addr_rs/rt.
  - CHECK, valid && ready: the pair is consumed. Go to POP if count != 0 after this cycle's update; otherwise go to IDLE.
  - CHECK, valid && !ready: stay in CHECK with the pair held stable.
- **Valid stability:** once ai_o_valid rises, it is not withdrawn until accepted, even if a set_en later hits an operand.
- **Reset:** all outputs are low/zero except ai_o_empty = 1; the state is IDLE; the scoreboard is cleared.
  - Reset mid-operation discards the held pair.
  - A pop already issued to the queue is not undone.
  - The queue must be reset together with this block.

## Timing
- **Pop-to-valid latency:** pop in cycle t, data captured at the end of t+1, earliest ai_o_valid in t+2.
- **First-pop latency:** a push in cycle t makes the count nonzero from t+1; the earliest pop is in t+2.
- **Throughput:** one pair per 3 cycles (POP, WAIT, CHECK), with back-to-back issue from CHECK to POP.
- **Set-to-stall:** a set_en in cycle t stalls a CHECK evaluation from t+1 onward.
- **Writeback-to-unstall:** a wb_en in cycle t unstalls the pair in the same cycle t (bypass), so ai_o_valid can be high in t.
- **Output registration:** ai_o_count, ai_o_empty and ai_o_overflow are registered. ai_o_valid, ai_o_stall and ai_o_pop are decoded from state and the scoreboard.

## Test plan
- **Basic drain:** reset 2 cycles, push 10 pairs (rs = rt = i, i = 0..9), ready held high → 10 issues in order 0..9, each exactly 3 cycles apart; count ends at 0; empty = 1.
- **Scoreboard stall:** set_en addr 3, push (3,4) → stall = 1 in CHECK and valid = 0. Then wb_en addr 3 → valid = 1 in that same cycle with rs = 3, rt = 4.
- **Set/clear collision:** set_en and wb_en both on addr 7 in one cycle → busy[7] = 1; a later pair (7,0) stalls.
- **Register 0 never busy:** set_en addr 0 → a pair (0,0) issues without stall.
- **Backpressure:** ready = 0 for 5 cycles in CHECK → valid stays high and the pair stays stable; exactly one pop occurs in total; the pair issues on the first cycle ready = 1.
- **Full, simultaneous and reset cases:**
  - 16 pushes with no pops → count = 16; a 17th push sets overflow = 1 and count stays 16.
  - Push and pop in the same cycle → count unchanged.
  - Reset asserted in CHECK → valid = 0, count = 0, overflow = 0 on the next cycle.
